// File: rtl/cdb_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// cdb_scheduler_pkg
// Shared types for the common-data-bus scheduler and its clients.
//   cdb_bus     : result bus format (tag + data) driven by each FU and the CDB
//   cdb_slot_t  : one reservation-table entry {valid, owner}
//   FU_*        : default functional-unit indices
// ---------------------------------------------------------------------------
package cdb_scheduler_pkg;

    localparam int CDB_TAG_W  = 6;
    localparam int CDB_DATA_W = 32;

    typedef struct packed {
        logic [CDB_TAG_W-1:0]  tag;
        logic [CDB_DATA_W-1:0] data;
    } cdb_bus;

    // Owner field width; bounds the largest FU count the table can encode.
    localparam int FU_IDW = 2;

    typedef struct packed {
        logic              valid;
        logic [FU_IDW-1:0] owner;
    } cdb_slot_t;

    localparam int FU_INT  = 0;
    localparam int FU_MEM  = 1;
    localparam int FU_MULT = 2;
    localparam int FU_DIV  = 3;

endpackage

// File: rtl/cdb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_rr_arbiter
// Round-robin request-to-grant arbiter. Grants the first requester at or
// above the rotating pointer (wrapping). The pointer moves to winner+1 only
// when more than one request was present, so an uncontested requester does
// not disturb the rotation.
// Ports:
//   clk, rst : clock, synchronous active-high reset (pointer -> 0)
//   i_req    : request vector
//   o_gnt    : one-hot (or zero) grant, combinational from i_req and pointer
// ---------------------------------------------------------------------------
module cdb_rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] i_req,
    output logic [N-1:0] o_gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_ptr_next;
    logic          w_found;
    logic          w_multi;

    always_comb begin
        int w_idx;
        o_gnt      = '0;
        w_found    = 1'b0;
        w_ptr_next = r_ptr;
        w_idx      = 0;
        for (int k = 0; k < N; k++) begin
            w_idx = (int'(r_ptr) + k) % N;
            if (!w_found && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                w_found      = 1'b1;
                w_ptr_next   = PW'((w_idx + 1) % N);
            end
        end
        w_multi = ($countones(i_req) > 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_multi) begin
            r_ptr <= w_ptr_next;
        end
    end

endmodule

// File: rtl/cdb_scheduler.sv
// ---------------------------------------------------------------------------
// cdb_scheduler
// Common-data-bus scheduler. A reservation table of MAX_LAT+1 future
// broadcast slots is shifted every cycle; an FU is granted issue only if the
// slot at its fixed latency is free, which makes every broadcast conflict-free
// by construction. Slot 0 selects which FU result drives the CDB.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   flush       : drop all reservations at the next edge, block grants now
//   issue_req   : per-FU issue request
//   issue_gnt   : per-FU combinational grant
//   fu_done     : per-FU "result presented on cdb_in" strobe
//   cdb_in      : per-FU result buses
//   CDB_output  : broadcast bus (zero when no slot owner)
//   cdb_valid   : broadcast valid
//   cdb_src     : owner index of current slot (0 when invalid)
//   sched_err   : sticky protocol error (fu_done vs. reservation mismatch)
// ---------------------------------------------------------------------------
module cdb_scheduler
    import cdb_scheduler_pkg::*;
#(
    parameter int NUM_FU          = 4,
    parameter int MAX_LAT         = 7,
    parameter int FU_LAT [NUM_FU] = '{1, 1, 4, 7},
    parameter bit RR_EN           = 1'b0,
    localparam int SRC_W          = $clog2(NUM_FU)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [NUM_FU-1:0] issue_req,
    output logic [NUM_FU-1:0] issue_gnt,
    input  logic [NUM_FU-1:0] fu_done,
    input  cdb_bus            cdb_in [NUM_FU],
    output cdb_bus            CDB_output,
    output logic              cdb_valid,
    output logic [SRC_W-1:0]  cdb_src,
    output logic              sched_err
);

    genvar gi;

    // ---------------- elaboration checks ----------------
    if (NUM_FU < 2) begin : g_chk_num
        $fatal(1, "cdb_scheduler: NUM_FU must be at least 2");
    end
    if (NUM_FU > (1 << FU_IDW)) begin : g_chk_idw
        $fatal(1, "cdb_scheduler: NUM_FU exceeds owner field width");
    end
    for (gi = 0; gi < NUM_FU; gi++) begin : g_chk_lat
        if (FU_LAT[gi] < 1 || FU_LAT[gi] > MAX_LAT) begin : g_bad
            $fatal(1, "cdb_scheduler: FU_LAT out of range 1..MAX_LAT");
        end
    end

    // FUs sharing a latency compete for the same slot; this mask marks them.
    function automatic logic [NUM_FU-1:0] lat_mask(input int lat);
        logic [NUM_FU-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            m[i] = (FU_LAT[i] == lat);
        end
        return m;
    endfunction

    cdb_slot_t         r_slot      [MAX_LAT+1];
    cdb_slot_t         w_slot_next [MAX_LAT+1];
    logic              r_err;
    logic              w_err;
    logic [NUM_FU-1:0] w_elig;
    logic [NUM_FU-1:0] w_gnt_grp   [1:MAX_LAT];

    // ---------------- eligibility ----------------
    for (gi = 0; gi < NUM_FU; gi++) begin : g_elig
        assign w_elig[gi] = issue_req[gi] && !r_slot[FU_LAT[gi]].valid && !flush;
    end

    // ---------------- per-latency arbitration ----------------
    for (gi = 1; gi <= MAX_LAT; gi++) begin : g_lat
        localparam logic [NUM_FU-1:0] LMASK = lat_mask(gi);
        logic [NUM_FU-1:0] w_grp_req;
        assign w_grp_req = w_elig & LMASK;

        if (LMASK == '0) begin : g_empty
            assign w_gnt_grp[gi] = '0;
        end else if (RR_EN) begin : g_rr
            cdb_rr_arbiter #(.N(NUM_FU)) u_arb (
                .clk   (clk),
                .rst   (rst),
                .i_req (w_grp_req),
                .o_gnt (w_gnt_grp[gi])
            );
        end else begin : g_fixed
            // Isolate the lowest set bit: lowest index wins.
            assign w_gnt_grp[gi] = w_grp_req & (~w_grp_req + NUM_FU'(1));
        end
    end

    always_comb begin
        issue_gnt = '0;
        for (int l = 1; l <= MAX_LAT; l++) begin
            issue_gnt = issue_gnt | w_gnt_grp[l];
        end
    end

    // ---------------- next-state of the reservation table ----------------
    always_comb begin
        for (int k = 0; k < MAX_LAT; k++) begin
            w_slot_next[k] = r_slot[k+1];
        end
        w_slot_next[MAX_LAT] = '0;
        // A slot at latency L now becomes index L-1 after this edge's shift.
        for (int i = 0; i < NUM_FU; i++) begin
            if (issue_gnt[i]) begin
                w_slot_next[FU_LAT[i]-1] = '{valid: 1'b1, owner: FU_IDW'(i)};
            end
        end
        if (flush) begin
            for (int k = 0; k <= MAX_LAT; k++) begin
                w_slot_next[k] = '0;
            end
        end
    end

    // ---------------- broadcast ----------------
    always_comb begin
        CDB_output = '0;
        cdb_valid  = 1'b0;
        cdb_src    = '0;
        if (r_slot[0].valid) begin
            cdb_valid = 1'b1;
            cdb_src   = SRC_W'(r_slot[0].owner);
            for (int i = 0; i < NUM_FU; i++) begin
                if (r_slot[0].owner == FU_IDW'(i)) begin
                    CDB_output = cdb_in[i];
                end
            end
        end
    end

    // ---------------- protocol check ----------------
    always_comb begin
        w_err = 1'b0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (fu_done[i] && !(r_slot[0].valid && r_slot[0].owner == FU_IDW'(i))) begin
                w_err = 1'b1;
            end
            if (r_slot[0].valid && r_slot[0].owner == FU_IDW'(i) && !fu_done[i]) begin
                w_err = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k <= MAX_LAT; k++) begin
                r_slot[k] <= '0;
            end
            r_err <= 1'b0;
        end else begin
            r_slot <= w_slot_next;
            r_err  <= r_err | w_err;
        end
    end

    assign sched_err = r_err;

endmodule

// File: tb/tb_cdb_scheduler.sv
// ---------------------------------------------------------------------------
// tb_cdb_scheduler
// Drives a fixed-priority and a round-robin scheduler with the same requests.
// The reference model books broadcasts by absolute cycle number and derives
// grants, broadcasts and the error flag from those bookings.
// ---------------------------------------------------------------------------
module tb_cdb_scheduler;
    import cdb_scheduler_pkg::*;

    localparam int NUM_FU  = 4;
    localparam int MAX_LAT = 7;
    localparam int LAT [NUM_FU] = '{1, 1, 4, 7};
    localparam int RES_LEN = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic [NUM_FU-1:0] issue_req = '0;
    logic [NUM_FU-1:0] fu_done_f = '0;
    logic [NUM_FU-1:0] fu_done_r = '0;
    cdb_bus            cdb_in [NUM_FU];

    logic [NUM_FU-1:0] gnt_f, gnt_r;
    cdb_bus            out_f, out_r;
    logic              valid_f, valid_r;
    logic [1:0]        src_f, src_r;
    logic              err_f, err_r;

    cdb_scheduler #(.NUM_FU(NUM_FU), .MAX_LAT(MAX_LAT), .FU_LAT(LAT), .RR_EN(1'b0)) dut_fix (
        .clk(clk), .rst(rst), .flush(flush), .issue_req(issue_req), .issue_gnt(gnt_f),
        .fu_done(fu_done_f), .cdb_in(cdb_in), .CDB_output(out_f), .cdb_valid(valid_f),
        .cdb_src(src_f), .sched_err(err_f)
    );

    cdb_scheduler #(.NUM_FU(NUM_FU), .MAX_LAT(MAX_LAT), .FU_LAT(LAT), .RR_EN(1'b1)) dut_rr (
        .clk(clk), .rst(rst), .flush(flush), .issue_req(issue_req), .issue_gnt(gnt_r),
        .fu_done(fu_done_r), .cdb_in(cdb_in), .CDB_output(out_r), .cdb_valid(valid_r),
        .cdb_src(src_r), .sched_err(err_r)
    );

    // Model state: res[c][t] = FU booked to broadcast in absolute cycle t, or -1.
    int res [2][RES_LEN];
    int rr_ptr [1:MAX_LAT];
    bit merr [2];
    int cyc = 0;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic fl, input logic [NUM_FU-1:0] req,
                        input logic [NUM_FU-1:0] corrupt, input bit chk);
        logic [NUM_FU-1:0] eg [2];
        logic [NUM_FU-1:0] fd [2];
        logic [NUM_FU-1:0] booked [2];
        int                nxt_ptr [1:MAX_LAT];
        logic [63:0]       rnd;
        cdb_bus            exp_out [2];

        // Drive inputs; each FU presents a result exactly when it is booked.
        rst = r; flush = fl; issue_req = req;
        for (int i = 0; i < NUM_FU; i++) begin
            rnd = {$urandom, $urandom};
            cdb_in[i] = rnd[$bits(cdb_bus)-1:0];
        end
        for (int c = 0; c < 2; c++) begin
            booked[c] = '0;
            exp_out[c] = '0;
            if (res[c][cyc] >= 0) begin
                booked[c][res[c][cyc]] = 1'b1;
                exp_out[c] = cdb_in[res[c][cyc]];
            end
            fd[c] = booked[c] ^ corrupt;
        end
        fu_done_f = fd[0];
        fu_done_r = fd[1];

        // Expected grants: one winner per latency whose target cycle is free.
        for (int l = 1; l <= MAX_LAT; l++) nxt_ptr[l] = rr_ptr[l];
        for (int c = 0; c < 2; c++) begin
            eg[c] = '0;
            for (int l = 1; l <= MAX_LAT; l++) begin
                bit el [NUM_FU];
                int cnt;
                int win;
                int idx;
                cnt = 0;
                win = -1;
                for (int i = 0; i < NUM_FU; i++) begin
                    el[i] = (LAT[i] == l) && req[i] && !fl && (res[c][cyc + l] < 0);
                    if (el[i]) cnt++;
                end
                if (cnt > 0) begin
                    for (int k = 0; k < NUM_FU; k++) begin
                        idx = (c == 0) ? k : (rr_ptr[l] + k) % NUM_FU;
                        if (win < 0 && el[idx]) win = idx;
                    end
                    eg[c][win] = 1'b1;
                    if (c == 1 && cnt > 1) nxt_ptr[l] = (win + 1) % NUM_FU;
                end
            end
        end

        @(negedge clk);
        if (chk) begin
            check_val("gnt_fix",   64'(gnt_f),   64'(eg[0]));
            check_val("valid_fix", 64'(valid_f), 64'(booked[0] != '0));
            check_val("src_fix",   64'(src_f),   64'(res[0][cyc] >= 0 ? res[0][cyc] : 0));
            check_val("cdb_fix",   64'(out_f),   64'(exp_out[0]));
            check_val("err_fix",   64'(err_f),   64'(merr[0]));
            check_val("gnt_rr",    64'(gnt_r),   64'(eg[1]));
            check_val("valid_rr",  64'(valid_r), 64'(booked[1] != '0));
            check_val("src_rr",    64'(src_r),   64'(res[1][cyc] >= 0 ? res[1][cyc] : 0));
            check_val("cdb_rr",    64'(out_r),   64'(exp_out[1]));
            check_val("err_rr",    64'(err_r),   64'(merr[1]));
        end
        @(posedge clk);
        #1;

        // Model update for the edge just taken.
        for (int c = 0; c < 2; c++) begin
            if (r) begin
                for (int t = cyc + 1; t <= cyc + MAX_LAT; t++) res[c][t] = -1;
                merr[c] = 1'b0;
            end else begin
                if (fd[c] != booked[c]) merr[c] = 1'b1;
                if (fl) begin
                    for (int t = cyc + 1; t <= cyc + MAX_LAT; t++) res[c][t] = -1;
                end else begin
                    for (int i = 0; i < NUM_FU; i++) begin
                        if (eg[c][i]) res[c][cyc + LAT[i]] = i;
                    end
                end
            end
        end
        for (int l = 1; l <= MAX_LAT; l++) rr_ptr[l] = r ? 0 : nxt_ptr[l];
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, '0, '0, 1'b1);
    endtask

    initial begin
        for (int c = 0; c < 2; c++) begin
            for (int t = 0; t < RES_LEN; t++) res[c][t] = -1;
            merr[c] = 1'b0;
        end
        for (int l = 1; l <= MAX_LAT; l++) rr_ptr[l] = 0;
        for (int i = 0; i < NUM_FU; i++) cdb_in[i] = '0;
        @(posedge clk);
        #1;

        // Reset with every input high; second cycle is checked.
        step(1'b1, 1'b1, 4'hF, 4'hF, 1'b0);
        step(1'b1, 1'b1, 4'hF, 4'hF, 1'b1);
        idle(2);

        // Single mult issue, broadcast four cycles later.
        step(1'b0, 1'b0, 4'b0100, '0, 1'b1);
        idle(5);

        // Div then int whose slot collides with the div broadcast.
        step(1'b0, 1'b0, 4'b1000, '0, 1'b1);
        idle(5);
        step(1'b0, 1'b0, 4'b0001, '0, 1'b1);
        step(1'b0, 1'b0, 4'b0001, '0, 1'b1);
        idle(3);

        // Same-cycle int/mem conflict for four cycles.
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 4'b0011, '0, 1'b1);
        idle(3);

        // Reserve mult, flush two cycles later with requests present.
        step(1'b0, 1'b0, 4'b0100, '0, 1'b1);
        idle(1);
        step(1'b0, 1'b1, 4'b0111, '0, 1'b1);
        idle(4);

        // Spurious fu_done[0]: sticky error until reset.
        step(1'b0, 1'b0, '0, 4'b0001, 1'b1);
        idle(4);
        step(1'b1, 1'b0, '0, '0, 1'b1);
        idle(2);

        // Randomized traffic with occasional flush, reset and protocol faults.
        for (int k = 0; k < 2000; k++) begin
            logic              r;
            logic              fl;
            logic [NUM_FU-1:0] rq;
            logic [NUM_FU-1:0] cor;
            r   = ($urandom_range(0, 99) < 2);
            fl  = ($urandom_range(0, 99) < 5);
            rq  = NUM_FU'($urandom);
            cor = ($urandom_range(0, 99) < 3) ? NUM_FU'(1 << $urandom_range(0, NUM_FU - 1)) : '0;
            step(r, fl, rq, cor, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
